rv32i_decode_exec: RTL and testbench



---
 rtl/rv32i_decode_exec.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_rv32i_decode_exec.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_exec.sv
// Single-cycle RV32I decode/execute slice: instruction decode, ALU, branch resolution
// and a sticky EBREAK halt latch. Only halt/halt_pc are registered.
module rv32i_decode_exec #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        alu_src,
    output logic        alu_r1,
    output logic [3:0]  alu_ctrl,
    output logic        alu_enable,
    output logic        wb_src,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_b,
    output logic [2:0]  b_type,
    output logic        br_taken,
    output logic [2:0]  is_load,
    output logic [2:0]  is_store,
    output logic [31:0] alu_result,
    output logic        overflow,
    output logic        illegal,
    output logic        halt,
    output logic [31:0] halt_pc
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic        shift_f7_ok_s;
    logic        op_f7_ok_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [31:0] alu_raw_s;
    logic        br_cond_s;
    logic        halt_r;
    logic [31:0] halt_pc_r;

    // Maps funct3 plus the instr[30] alternate bit onto the ALU operation code.
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        case (f3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            3'b111:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];
    assign rs1      = instruction[19:15];
    assign rs2      = instruction[24:20];
    assign rd       = instruction[11:7];

    assign imm_i_s = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b_s = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u_s = {instruction[31:12], 12'h000};
    assign imm_j_s = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    // Shift-immediates accept only the plain or arithmetic funct7; register ops allow the
    // alternate funct7 only where it selects SUB or SRA.
    assign shift_f7_ok_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
    assign op_f7_ok_s    = (funct7_s == 7'b0000000) ||
                           ((funct7_s == 7'b0100000) &&
                            ((funct3_s == 3'b000) || (funct3_s == 3'b101)));

    // Instruction decode; any illegal encoding leaves every control at its inactive value.
    always_comb begin
        imm        = 32'd0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_r1     = 1'b0;
        alu_ctrl   = ALU_ADD;
        alu_enable = 1'b0;
        wb_src     = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_b       = 1'b0;
        is_load    = 3'b111;
        is_store   = 3'b111;
        illegal    = 1'b0;
        case (opcode_s)
            OP_LUI: begin
                imm        = imm_u_s;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                alu_enable = 1'b1;
                wb_src     = 1'b1;
            end
            OP_AUIPC: begin
                imm        = imm_u_s;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                alu_r1     = 1'b1;
                alu_enable = 1'b1;
            end
            OP_JAL: begin
                imm        = imm_j_s;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                alu_r1     = 1'b1;
                alu_enable = 1'b1;
                is_jal     = 1'b1;
            end
            OP_JALR: begin
                if (funct3_s == 3'b000) begin
                    imm        = imm_i_s;
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    alu_enable = 1'b1;
                    is_jalr    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
                    illegal = 1'b1;
                end else begin
                    imm        = imm_b_s;
                    alu_ctrl   = ALU_SUB;
                    alu_enable = 1'b1;
                    is_b       = 1'b1;
                end
            end
            OP_LOAD: begin
                if ((funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111)) begin
                    illegal = 1'b1;
                end else begin
                    imm        = imm_i_s;
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    alu_enable = 1'b1;
                    is_load    = funct3_s;
                end
            end
            OP_STORE: begin
                if (funct3_s <= 3'b010) begin
                    imm        = imm_s_s;
                    alu_src    = 1'b1;
                    alu_enable = 1'b1;
                    is_store   = funct3_s;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                if (((funct3_s == 3'b001) || (funct3_s == 3'b101)) && !shift_f7_ok_s) begin
                    illegal = 1'b1;
                end else begin
                    imm        = imm_i_s;
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    alu_enable = 1'b1;
                    alu_ctrl   = alu_sel(funct3_s, (funct3_s == 3'b101) && instruction[30]);
                end
            end
            OP_REG: begin
                if (op_f7_ok_s) begin
                    reg_write  = 1'b1;
                    alu_enable = 1'b1;
                    alu_ctrl   = alu_sel(funct3_s, instruction[30]);
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_SYSTEM: begin
                if ((instruction == INSN_ECALL) || (instruction == INSN_EBREAK)) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign op_a_s = alu_r1 ? pc : rs1_data;
    assign op_b_s = alu_src ? imm : rs2_data;
    assign sum_s  = op_a_s + op_b_s;
    assign diff_s = op_a_s - op_b_s;

    // ALU datapath; disabled slots produce zero and JALR targets drop bit 0.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD:  alu_raw_s = sum_s;
            ALU_SUB:  alu_raw_s = diff_s;
            ALU_SLL:  alu_raw_s = op_a_s << op_b_s[4:0];
            ALU_SLT:  alu_raw_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
            ALU_SLTU: alu_raw_s = {31'd0, (op_a_s < op_b_s)};
            ALU_XOR:  alu_raw_s = op_a_s ^ op_b_s;
            ALU_SRL:  alu_raw_s = op_a_s >> op_b_s[4:0];
            ALU_SRA:  alu_raw_s = $unsigned($signed(op_a_s) >>> op_b_s[4:0]);
            ALU_OR:   alu_raw_s = op_a_s | op_b_s;
            ALU_AND:  alu_raw_s = op_a_s & op_b_s;
            default:  alu_raw_s = 32'd0;
        endcase
        if (!alu_enable) begin
            alu_result = 32'd0;
        end else if (is_jalr) begin
            alu_result = alu_raw_s & 32'hFFFF_FFFE;
        end else begin
            alu_result = alu_raw_s;
        end
    end

    // Signed overflow of the adder, reported only for ADD and SUB operations.
    always_comb begin
        if (alu_enable && (alu_ctrl == ALU_ADD)) begin
            overflow = (op_a_s[31] == op_b_s[31]) && (sum_s[31] != op_a_s[31]);
        end else if (alu_enable && (alu_ctrl == ALU_SUB)) begin
            overflow = (op_a_s[31] != op_b_s[31]) && (diff_s[31] != op_a_s[31]);
        end else begin
            overflow = 1'b0;
        end
    end

    // Branch condition straight from the register operands.
    always_comb begin
        case (funct3_s)
            3'b000:  br_cond_s = (rs1_data == rs2_data);
            3'b001:  br_cond_s = (rs1_data != rs2_data);
            3'b100:  br_cond_s = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  br_cond_s = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_cond_s = (rs1_data < rs2_data);
            3'b111:  br_cond_s = (rs1_data >= rs2_data);
            default: br_cond_s = 1'b0;
        endcase
        if (is_b) begin
            b_type   = funct3_s;
            br_taken = br_cond_s;
        end else begin
            b_type   = 3'b111;
            br_taken = 1'b0;
        end
    end

    // Sticky halt: first EBREAK after reset captures its PC; reset always wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halt_r    <= 1'b0;
            halt_pc_r <= RESET_PC;
        end else if (!halt_r && (instruction == INSN_EBREAK)) begin
            halt_r    <= 1'b1;
            halt_pc_r <= pc;
        end else begin
            halt_r    <= halt_r;
            halt_pc_r <= halt_pc_r;
        end
    end

    assign halt    = halt_r;
    assign halt_pc = halt_pc_r;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Randomized self-checking bench for rv32i_decode_exec against a mnemonic-level
// reference model, plus literal spot checks of known encodings.
module tb_rv32i_decode_exec;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    typedef struct packed {
        logic [31:0] imm;
        logic        reg_write;
        logic        alu_src;
        logic        alu_r1;
        logic [3:0]  alu_ctrl;
        logic        alu_enable;
        logic        wb_src;
        logic        is_jal;
        logic        is_jalr;
        logic        is_b;
        logic [2:0]  b_type;
        logic        br_taken;
        logic [2:0]  is_load;
        logic [2:0]  is_store;
        logic [31:0] alu_result;
        logic        overflow;
        logic        illegal;
        logic        chk_alu;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        reg_write;
    logic        alu_src;
    logic        alu_r1;
    logic [3:0]  alu_ctrl;
    logic        alu_enable;
    logic        wb_src;
    logic        is_jal;
    logic        is_jalr;
    logic        is_b;
    logic [2:0]  b_type;
    logic        br_taken;
    logic [2:0]  is_load;
    logic [2:0]  is_store;
    logic [31:0] alu_result;
    logic        overflow;
    logic        illegal;
    logic        halt;
    logic [31:0] halt_pc;

    int          checks;
    int          errors;
    logic        exp_halt;
    logic [31:0] exp_halt_pc;
    logic        halt_known;

    rv32i_decode_exec #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .reg_write(reg_write), .alu_src(alu_src), .alu_r1(alu_r1), .alu_ctrl(alu_ctrl),
        .alu_enable(alu_enable), .wb_src(wb_src), .is_jal(is_jal), .is_jalr(is_jalr),
        .is_b(is_b), .b_type(b_type), .br_taken(br_taken),
        .is_load(is_load), .is_store(is_store), .alu_result(alu_result),
        .overflow(overflow), .illegal(illegal), .halt(halt), .halt_pc(halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s;
        s = x + y;
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

    function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s;
        s = x - y;
        return (x[31] != y[31]) && (s[31] != x[31]);
    endfunction

    // Result of the arithmetic/logic mnemonics named by funct3 (alt = SUB/SRA variant).
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
        int sh;
        sh = int'(y % 32);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << sh;
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? $unsigned($signed(x) >>> sh) : x >> sh;
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic [3:0] code_of(input logic [2:0] f3, input logic alt);
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return tab[f3];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic        alt;
        f3    = ins[14:12];
        f7    = ins[31:25];
        i_imm = {{20{ins[31]}}, ins[31:20]};
        s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = {ins[31:12], 12'h000};
        j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '0;
        e.b_type = 3'b111; e.is_load = 3'b111; e.is_store = 3'b111; e.chk_alu = 1'b1;
        case (ins[6:0])
            7'h37: begin
                e.imm = u_imm; e.reg_write = 1'b1; e.alu_src = 1'b1;
                e.alu_enable = 1'b1; e.wb_src = 1'b1; e.chk_alu = 1'b0;
            end
            7'h17: begin
                e.imm = u_imm; e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_r1 = 1'b1;
                e.alu_enable = 1'b1; e.alu_result = pcv + u_imm; e.overflow = add_ovf(pcv, u_imm);
            end
            7'h6F: begin
                e.imm = j_imm; e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_r1 = 1'b1;
                e.alu_enable = 1'b1; e.is_jal = 1'b1;
                e.alu_result = pcv + j_imm; e.overflow = add_ovf(pcv, j_imm);
            end
            7'h67: begin
                if (f3 == 3'd0) begin
                    e.imm = i_imm; e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_enable = 1'b1;
                    e.is_jalr = 1'b1;
                    e.alu_result = (a + i_imm) & 32'hFFFF_FFFE; e.overflow = add_ovf(a, i_imm);
                end else e.illegal = 1'b1;
            end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1'b1;
                else begin
                    e.imm = b_imm; e.alu_ctrl = 4'd1; e.alu_enable = 1'b1; e.is_b = 1'b1;
                    e.b_type = f3; e.alu_result = a - b; e.overflow = sub_ovf(a, b);
                    case (f3)
                        3'd0:    e.br_taken = (a == b);
                        3'd1:    e.br_taken = (a != b);
                        3'd4:    e.br_taken = ($signed(a) < $signed(b));
                        3'd5:    e.br_taken = ($signed(a) >= $signed(b));
                        3'd6:    e.br_taken = (a < b);
                        default: e.br_taken = (a >= b);
                    endcase
                end
            end
            7'h03: begin
                if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) begin
                    e.imm = i_imm; e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_enable = 1'b1;
                    e.is_load = f3; e.alu_result = a + i_imm; e.overflow = add_ovf(a, i_imm);
                end else e.illegal = 1'b1;
            end
            7'h23: begin
                if (f3 < 3'd3) begin
                    e.imm = s_imm; e.alu_src = 1'b1; e.alu_enable = 1'b1; e.is_store = f3;
                    e.alu_result = a + s_imm; e.overflow = add_ovf(a, s_imm);
                end else e.illegal = 1'b1;
            end
            7'h13: begin
                if ((f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20)) e.illegal = 1'b1;
                else begin
                    alt = (f3 == 3'd5) && ins[30];
                    e.imm = i_imm; e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_enable = 1'b1;
                    e.alu_ctrl = code_of(f3, alt); e.alu_result = arith(f3, alt, a, i_imm);
                    e.overflow = (f3 == 3'd0) ? add_ovf(a, i_imm) : 1'b0;
                end
            end
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    alt = (f7 == 7'h20);
                    e.reg_write = 1'b1; e.alu_enable = 1'b1;
                    e.alu_ctrl = code_of(f3, alt); e.alu_result = arith(f3, alt, a, b);
                    e.overflow = (f3 == 3'd0) ? (alt ? sub_ovf(a, b) : add_ovf(a, b)) : 1'b0;
                end else e.illegal = 1'b1;
            end
            7'h73: e.illegal = !(ins == ECALL || ins == EBREAK);
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: ins=%08h got %08h expected %08h", name, instruction, act, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic compare_all();
        exp_t e;
        e = model(instruction, pc, rs1_data, rs2_data);
        chk("rs1", {27'd0, rs1}, {27'd0, instruction[19:15]});
        chk("rs2", {27'd0, rs2}, {27'd0, instruction[24:20]});
        chk("rd", {27'd0, rd}, {27'd0, instruction[11:7]});
        chk("imm", imm, e.imm);
        chk("reg_write", {31'd0, reg_write}, {31'd0, e.reg_write});
        chk("alu_src", {31'd0, alu_src}, {31'd0, e.alu_src});
        chk("alu_r1", {31'd0, alu_r1}, {31'd0, e.alu_r1});
        chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.alu_ctrl});
        chk("alu_enable", {31'd0, alu_enable}, {31'd0, e.alu_enable});
        chk("wb_src", {31'd0, wb_src}, {31'd0, e.wb_src});
        chk("is_jal", {31'd0, is_jal}, {31'd0, e.is_jal});
        chk("is_jalr", {31'd0, is_jalr}, {31'd0, e.is_jalr});
        chk("is_b", {31'd0, is_b}, {31'd0, e.is_b});
        chk("b_type", {29'd0, b_type}, {29'd0, e.b_type});
        chk("br_taken", {31'd0, br_taken}, {31'd0, e.br_taken});
        chk("is_load", {29'd0, is_load}, {29'd0, e.is_load});
        chk("is_store", {29'd0, is_store}, {29'd0, e.is_store});
        chk("illegal", {31'd0, illegal}, {31'd0, e.illegal});
        if (e.chk_alu) begin
            chk("alu_result", alu_result, e.alu_result);
            chk("overflow", {31'd0, overflow}, {31'd0, e.overflow});
        end
        if (halt_known) begin
            chk("halt", {31'd0, halt}, {31'd0, exp_halt});
            chk("halt_pc", halt_pc, exp_halt_pc);
        end
    endtask

    task automatic apply(input logic r, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        rst = r; instruction = ins; pc = p; rs1_data = a; rs2_data = b;
        @(negedge clk);
        compare_all();
    endtask

    // Advance the halt model with the inputs held across the coming rising edge.
    task automatic advance();
        if (!rst) begin
            exp_halt = 1'b0; exp_halt_pc = RESET_PC; halt_known = 1'b1;
        end else if (!exp_halt && instruction == EBREAK) begin
            exp_halt = 1'b1; exp_halt_pc = pc;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] rnd, ins, p, a, b;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        r;
        checks = 0; errors = 0; halt_known = 1'b0;
        exp_halt = 1'b0; exp_halt_pc = RESET_PC;
        rst = 1'b0; instruction = 32'h0000_0013; pc = RESET_PC; rs1_data = 32'd0; rs2_data = 32'd0;
        @(posedge clk);
        #1;

        apply(1'b0, 32'h0000_0013, RESET_PC, 32'd0, 32'd0);
        advance();
        apply(1'b1, 32'h0050_0093, RESET_PC, 32'd0, 32'd0);
        chk("lit_reset_halt", {31'd0, halt}, 32'd0);
        chk("lit_reset_halt_pc", halt_pc, 32'h8000_0000);
        chk("lit_addi_rd", {27'd0, rd}, 32'd1);
        chk("lit_addi_imm", imm, 32'd5);
        chk("lit_addi_rw", {31'd0, reg_write}, 32'd1);
        chk("lit_addi_src", {31'd0, alu_src}, 32'd1);
        chk("lit_addi_res", alu_result, 32'd5);
        advance();
        apply(1'b1, 32'h4020_81B3, RESET_PC, 32'h8000_0000, 32'd1);
        chk("lit_sub_res", alu_result, 32'h7FFF_FFFF);
        chk("lit_sub_ovf", {31'd0, overflow}, 32'd1);
        advance();
        apply(1'b1, 32'h1234_52B7, RESET_PC, 32'd0, 32'd0);
        chk("lit_lui_imm", imm, 32'h1234_5000);
        chk("lit_lui_wb", {31'd0, wb_src}, 32'd1);
        chk("lit_lui_rw", {31'd0, reg_write}, 32'd1);
        chk("lit_lui_ill", {31'd0, illegal}, 32'd0);
        advance();
        apply(1'b1, 32'h0020_8463, RESET_PC, 32'd7, 32'd7);
        chk("lit_beq_isb", {31'd0, is_b}, 32'd1);
        chk("lit_beq_type", {29'd0, b_type}, 32'd0);
        chk("lit_beq_taken", {31'd0, br_taken}, 32'd1);
        chk("lit_beq_imm", imm, 32'd8);
        advance();
        apply(1'b1, 32'h0020_8463, RESET_PC, 32'd7, 32'd8);
        chk("lit_beq_not_taken", {31'd0, br_taken}, 32'd0);
        advance();
        apply(1'b1, 32'hFFC1_2303, RESET_PC, 32'h0000_0100, 32'd0);
        chk("lit_lw_load", {29'd0, is_load}, 32'd2);
        chk("lit_lw_imm", imm, 32'hFFFF_FFFC);
        chk("lit_lw_res", alu_result, 32'h0000_00FC);
        advance();
        apply(1'b1, ECALL, RESET_PC, 32'd3, 32'd4);
        chk("lit_ecall_ill", {31'd0, illegal}, 32'd0);
        chk("lit_ecall_rw", {31'd0, reg_write}, 32'd0);
        advance();
        apply(1'b1, EBREAK, 32'h8000_0010, 32'd0, 32'd0);
        advance();
        apply(1'b1, EBREAK, 32'h8000_0020, 32'd0, 32'd0);
        chk("lit_ebreak_halt", {31'd0, halt}, 32'd1);
        chk("lit_ebreak_pc", halt_pc, 32'h8000_0010);
        advance();
        apply(1'b0, EBREAK, 32'h8000_0030, 32'd0, 32'd0);
        chk("lit_halt_frozen", halt_pc, 32'h8000_0010);
        advance();
        apply(1'b1, 32'h0050_0093, RESET_PC, 32'd0, 32'd0);
        chk("lit_reset_wins", {31'd0, halt}, 32'd0);
        chk("lit_reset_wins_pc", halt_pc, 32'h8000_0000);
        advance();

        for (int n = 0; n < 3000; n++) begin
            rnd = $urandom;
            f3  = rnd[14:12];
            case ($urandom_range(0, 10))
                0: ins = {rnd[31:7], 7'h37};
                1: ins = {rnd[31:7], 7'h17};
                2: ins = {rnd[31:7], 7'h6F};
                3: ins = {rnd[31:15], ($urandom_range(0, 5) == 0) ? f3 : 3'd0, rnd[11:7], 7'h67};
                4: ins = {rnd[31:7], 7'h63};
                5: ins = {rnd[31:7], 7'h03};
                6: ins = {rnd[31:7], 7'h23};
                7: begin
                    case ($urandom_range(0, 3))
                        0: f7 = 7'h00;
                        1: f7 = 7'h20;
                        default: f7 = rnd[31:25];
                    endcase
                    if (f3 == 3'd1 && f7 == 7'h20) f7 = 7'h00;
                    ins = {f7, rnd[24:7], 7'h13};
                end
                8: begin
                    case ($urandom_range(0, 3))
                        0: f7 = 7'h00;
                        1: f7 = (f3 == 3'd0 || f3 == 3'd5) ? 7'h20 : 7'h00;
                        2: f7 = 7'h01;
                        default: f7 = rnd[31:25];
                    endcase
                    if (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)) f7 = 7'h01;
                    ins = {f7, rnd[24:7], 7'h33};
                end
                9: begin
                    case ($urandom_range(0, 2))
                        0: ins = ECALL;
                        1: ins = EBREAK;
                        default: ins = {rnd[31:7], 7'h73};
                    endcase
                end
                default: begin
                    case (rnd[1:0])
                        2'd0: ins = {rnd[31:7], 7'h00};
                        2'd1: ins = {rnd[31:7], 7'h7F};
                        2'd2: ins = {rnd[31:7], 7'h53};
                        default: ins = {rnd[31:7], 7'h0B};
                    endcase
                end
            endcase
            p = ($urandom_range(0, 1) == 0) ? (RESET_PC + {20'd0, rnd[13:2], 2'b00}) : pick_data();
            a = pick_data();
            b = ($urandom_range(0, 2) == 0) ? a : pick_data();
            r = ($urandom_range(0, 24) != 0);
            apply(r, ins, p, a, b);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
